// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT sequencing, redirect priority and an
// optional return-address stack compiled in by defining PC_RAS_EN.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             exc_valid,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             pc_valid,
    output logic             ras_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic             pc_valid_q;

    logic             ret_redirect_c;
    logic [WIDTH-1:0] ret_pc_c;

    assign pc          = pc_q;
    assign pc_next_seq = pc_q + WIDTH'(INC);
    assign pc_valid    = pc_valid_q;

`ifdef PC_RAS_EN
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [CW-1:0]    ptr_q, ptr_d;
    logic             ras_err_q, ras_err_d;
    logic             pop_en_c, push_en_c, wr_en_c;
    logic [IW-1:0]    wr_idx_c;

    // Stack ops only happen when no exception, halt or branch outranks them.
    assign pop_en_c  = (state_q == ST_RUN) & ~exc_valid & ~halt & ~br_valid & ret;
    assign push_en_c = (state_q == ST_RUN) & ~exc_valid & ~halt & ~br_valid & call
                       & (ret | ~stall);

    assign ret_redirect_c = pop_en_c;
    assign ras_err        = ras_err_q;

    // Pop first, then push into the post-pop depth.
    always_comb begin
        ptr_d     = ptr_q;
        ras_err_d = ras_err_q;
        ret_pc_c  = pc_next_seq;
        wr_en_c   = 1'b0;
        wr_idx_c  = '0;
        if (pop_en_c) begin
            if (ptr_q == '0) begin
                ras_err_d = 1'b1;
            end else begin
                ret_pc_c = ras_q[IW'(ptr_q - 1'b1)];
                ptr_d    = ptr_q - 1'b1;
            end
        end
        if (push_en_c) begin
            wr_en_c = 1'b1;
            if (ptr_d == CW'(RAS_DEPTH)) begin
                wr_idx_c  = IW'(RAS_DEPTH - 1);
                ras_err_d = 1'b1;
            end else begin
                wr_idx_c = IW'(ptr_d);
                ptr_d    = ptr_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            ras_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            ras_err_q <= ras_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            ras_q[wr_idx_c] <= pc_next_seq;
        end
    end
`else
    logic [31:0] unused_c;

    assign ret_redirect_c = 1'b0;
    assign ret_pc_c       = pc_next_seq;
    assign ras_err        = 1'b0;
    assign unused_c       = {31'b0, call ^ ret} ^ 32'(RAS_DEPTH);
`endif

    // Sequencer: exception > halt > branch > return > stall > sequential.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    pc_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (exc_valid) begin
                        pc_q <= EXC_VECTOR;
                    end else if (halt) begin
                        state_q    <= ST_HALT;
                        pc_valid_q <= 1'b0;
                    end else if (br_valid) begin
                        pc_q <= br_target;
                    end else if (ret_redirect_c) begin
                        pc_q <= ret_pc_c;
                    end else if (!stall) begin
                        pc_q <= pc_next_seq;
                    end
                end
                ST_HALT: begin
                    if (exc_valid) begin
                        pc_q       <= EXC_VECTOR;
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end else if (resume) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector tables, hand-written reset/wrap sequences
// and a randomized run against a queue-based reference model.
module tb_pc_unit;

    localparam int unsigned RAS_D = 2;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt, resume, exc_valid, br_valid, call, ret;
    logic [31:0] br_target;
    logic [31:0] pc, pc_next_seq;
    logic        pc_valid, ras_err;

    logic        s_zero, s_br_valid;
    logic [7:0]  s_br_target, s_pc, s_next;
    logic        s_valid, s_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .INC(4),
              .RAS_DEPTH(RAS_D)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .exc_valid(exc_valid), .br_valid(br_valid), .br_target(br_target),
        .call(call), .ret(ret), .pc(pc), .pc_next_seq(pc_next_seq),
        .pc_valid(pc_valid), .ras_err(ras_err));

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80), .INC(4),
              .RAS_DEPTH(RAS_D)) dut8 (
        .clk(clk), .rst(rst), .stall(s_zero), .halt(s_zero), .resume(s_zero),
        .exc_valid(s_zero), .br_valid(s_br_valid), .br_target(s_br_target),
        .call(s_zero), .ret(s_zero), .pc(s_pc), .pc_next_seq(s_next),
        .pc_valid(s_valid), .ras_err(s_err));

    typedef struct {
        logic        st, hl, rs, ex, br;
        logic [31:0] tg;
        logic        cl, rt;
        logic [31:0] exp_pc;
        logic        exp_valid, exp_err;
    } vec_t;

    typedef enum {M_BOOT, M_RUN, M_HALT} mst_e;
    mst_e        m_state;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_stk[$];

    function automatic vec_t mk(input logic st, hl, rs, ex, br, input logic [31:0] tg,
                                input logic cl, rt, input logic [31:0] epc,
                                input logic ev, ee);
        vec_t v;
        v.st = st; v.hl = hl; v.rs = rs; v.ex = ex; v.br = br; v.tg = tg;
        v.cl = cl; v.rt = rt; v.exp_pc = epc; v.exp_valid = ev; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [31:0] epc,
                             input logic ev, input logic ee);
        check({name, ".pc"}, pc, epc);
        check({name, ".next_seq"}, pc_next_seq, epc + 32'd4);
        check({name, ".valid"}, {31'b0, pc_valid}, {31'b0, ev});
        check({name, ".ras_err"}, {31'b0, ras_err}, {31'b0, ee});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        stall = v.st; halt = v.hl; resume = v.rs; exc_valid = v.ex;
        br_valid = v.br; br_target = v.tg; call = v.cl; ret = v.rt;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; resume = 0; exc_valid = 0; br_valid = 0;
        br_target = '0; call = 0; ret = 0; s_br_valid = 0; s_br_target = '0;
    endtask

    // Hold reset two cycles, release, and check the BOOT cycle.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_all("in_reset", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        check_all("boot", 32'h0, 1'b0, 1'b0);
    endtask

    task automatic run_table(input string name, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            check_all($sformatf("%s[%0d]", name, i), tbl[i].exp_pc,
                      tbl[i].exp_valid, tbl[i].exp_err);
        end
        idle_inputs();
    endtask

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = 32'h0;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_push(input logic [31:0] v);
        if (m_stk.size() == RAS_D) begin
            m_stk[m_stk.size() - 1] = v;
            m_err = 1'b1;
        end else begin
            m_stk.push_back(v);
        end
    endtask

    // One clock edge of the architectural behaviour, driven by the rules.
    task automatic model_step(input logic st, hl, rs, ex, br, input logic [31:0] tg,
                              input logic cl, rt);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        case (m_state)
            M_BOOT: m_state = M_RUN;
            M_HALT: begin
                if (ex) begin
                    m_pc = 32'h80; m_state = M_RUN;
                end else if (rs) begin
                    m_state = M_RUN;
                end
            end
            default: begin
                if (ex) m_pc = 32'h80;
                else if (hl) m_state = M_HALT;
                else if (br) m_pc = tg;
                else if (RAS_ON && rt) begin
                    if (m_stk.size() == 0) begin
                        m_err = 1'b1;
                        m_pc  = seq;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                    if (cl) model_push(seq);
                end else begin
                    if (RAS_ON && cl && !st) model_push(seq);
                    if (!st) m_pc = seq;
                end
            end
        endcase
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rv;
        s_zero = 1'b0;
        rst    = 1'b1;
        idle_inputs();

        // Reset, stall vs. branch, priority, halt/resume.
        do_reset();
        tbl = {};
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h0,   1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h4,   1,0));
        tbl.push_back(mk(1,0,0,0,1,32'h100,0,0, 32'h100, 1,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0,  0,0, 32'h100, 1,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0,  0,0, 32'h100, 1,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0,  0,0, 32'h100, 1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h104, 1,0));
        tbl.push_back(mk(0,0,0,0,1,32'h40, 0,0, 32'h40,  1,0));
        tbl.push_back(mk(0,1,0,1,1,32'h200,0,0, 32'h80,  1,0));
        tbl.push_back(mk(0,0,0,0,1,32'h20, 0,0, 32'h20,  1,0));
        tbl.push_back(mk(0,1,0,0,0,32'h0,  0,0, 32'h20,  0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h20,  0,0));
        tbl.push_back(mk(0,0,0,0,1,32'h300,1,1, 32'h20,  0,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h20,  0,0));
        tbl.push_back(mk(1,1,0,0,0,32'h0,  0,0, 32'h20,  0,0));
        tbl.push_back(mk(0,1,1,0,0,32'h0,  0,0, 32'h20,  1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h24,  1,0));
        tbl.push_back(mk(0,1,0,0,0,32'h0,  0,0, 32'h24,  0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,  0,0, 32'h80,  1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0,  0,0, 32'h84,  1,0));
        tbl.push_back(mk(0,1,0,0,1,32'h500,0,0, 32'h84,  0,0));
        tbl.push_back(mk(0,0,1,0,0,32'h0,  0,0, 32'h84,  1,0));
        run_table("basic", tbl);

        // Asynchronous reset with a branch pending, branch still high in BOOT.
        br_valid = 1'b1; br_target = 32'h700;
        #2 rst = 1'b1;
        #1 check_all("async_rst", 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_all("rst_rel", 32'h0, 1'b0, 1'b0);
        tick();
        check_all("rst_boot_ignores_br", 32'h0, 1'b1, 1'b0);
        br_valid = 1'b0;
        tick();
        check_all("rst_first_seq", 32'h4, 1'b1, 1'b0);

        // 8-bit wrap from 0xFC to 0x00.
        do_reset();
        tick();
        s_br_valid = 1'b1; s_br_target = 8'hFC;
        tick();
        s_br_valid = 1'b0;
        check("wrap.pc_fc", {24'b0, s_pc}, 32'hFC);
        check("wrap.next_seq", {24'b0, s_next}, 32'h00);
        tick();
        check("wrap.pc_00", {24'b0, s_pc}, 32'h00);
        check("wrap.valid", {31'b0, s_valid}, 32'h1);
        check("wrap.err", {31'b0, s_err}, 32'h0);

        // Return stack sequence (or its absence).
        do_reset();
        tbl = {};
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,0, 32'h0,  1,0));
        tbl.push_back(mk(0,0,0,0,1,32'h10,0,0, 32'h10, 1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0, 1,0, 32'h14, 1,0));
        tbl.push_back(mk(0,0,0,0,1,32'h50,0,0, 32'h50, 1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0, 1,0, 32'h54, 1,0));
`ifdef PC_RAS_EN
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,1, 32'h54, 1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,1, 32'h14, 1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,1, 32'h18, 1,1));
        tbl.push_back(mk(1,0,0,0,0,32'h0, 0,0, 32'h18, 1,1));
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,0, 32'h1C, 1,1));
`else
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,1, 32'h58, 1,0));
        tbl.push_back(mk(1,0,0,0,0,32'h0, 1,1, 32'h58, 1,0));
        tbl.push_back(mk(0,0,0,0,0,32'h0, 0,1, 32'h5C, 1,0));
`endif
        run_table("ras", tbl);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end else begin
                rv = mk($urandom_range(0,3) == 0, $urandom_range(0,15) == 0,
                        $urandom_range(0,3) == 0, $urandom_range(0,31) == 0,
                        $urandom_range(0,7) == 0, $urandom & 32'hFFFF_FFFC,
                        $urandom_range(0,5) == 0, $urandom_range(0,5) == 0,
                        32'h0, 1'b0, 1'b0);
                drive(rv);
                model_step(rv.st, rv.hl, rv.rs, rv.ex, rv.br, rv.tg, rv.cl, rv.rt);
                tick();
            end
            check_all($sformatf("rand[%0d]", i), m_pc, m_state == M_RUN, m_err);
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0080: exception entry address.
REQ-004 SHALL have parameter INC, default 4: sequential increment.
REQ-005 SHALL have parameter RAS_DEPTH, default 4: return-stack entries; used only with PC_RAS_EN.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port stall, input, 1: hold the PC.
REQ-009 SHALL have port halt, input, 1: enter HALT.
REQ-010 SHALL have port resume, input, 1: leave HALT.
REQ-011 SHALL have port exc_valid, input, 1: exception redirect request.
REQ-012 SHALL have port br_valid, input, 1: branch or jump redirect request.
REQ-013 SHALL have port br_target, input, WIDTH: branch or jump target.
REQ-014 SHALL have port call, input, 1: current instruction is a call (PC_RAS_EN only).
REQ-015 SHALL have port ret, input, 1: current instruction is a return (PC_RAS_EN only).
REQ-016 SHALL have port pc, output, WIDTH: current fetch address.
REQ-017 SHALL have port pc_next_seq, output, WIDTH: pc+INC, combinational.
REQ-018 SHALL have port pc_valid, output, 1: pc is a valid fetch address this cycle.
REQ-019 SHALL have port ras_err, output, 1: sticky stack overflow/underflow flag (PC_RAS_EN only; otherwise tied 0).

Function
REQ-020 SHALL implement FSM states BOOT, RUN, HALT.
- BOOT: after reset; lasts exactly 1 cycle; pc_valid=0; then goes to RUN.
- RUN: pc_valid=1.
- HALT: pc_valid=0; pc is held.
REQ-021 SHALL, in RUN, select next pc by priority exc_valid > br_valid > ret (RAS) > stall > sequential.
- Exception: load EXC_VECTOR.
- Branch: load br_target.
- Return: load the popped RAS entry.
- Stall: hold pc.
- Sequential: load pc+INC.
REQ-022 SHALL make redirects (exception, branch, return) override stall in the same cycle; the loaded value is visible on pc the next cycle, with 1-cycle latency.
REQ-023 SHALL compute pc+INC modulo 2^WIDTH; all-ones minus INC+1 wraps to low addresses, with no flag.
REQ-024 SHALL, on halt=1 in RUN, move to HALT next cycle without updating pc, unless exc_valid is also asserted; then EXC_VECTOR is loaded and the FSM stays in RUN.
REQ-025 SHALL, on resume=1 in HALT, move to RUN next cycle with pc unchanged; if halt and resume are both asserted, resume wins.
REQ-026 SHALL, on exc_valid in HALT, load EXC_VECTOR and move to RUN.
REQ-027 SHALL ignore br_valid, call, and ret in BOOT and HALT.
REQ-028 SHALL drive pc_next_seq from the registered pc in every state.

Reset
REQ-029 SHALL, on rst=1 asynchronously, set:
- pc=RESET_VECTOR
- state=BOOT
- pc_valid=0
- ras_err=0
- RAS pointer=0 (empty)
REQ-030 SHALL, on reset asserted mid-operation, discard any pending redirect; the first valid pc after release is RESET_VECTOR, presented one cycle after BOOT.

Configuration
REQ-031 SHALL compile in the return-address stack only when macro PC_RAS_EN is defined.
REQ-032 SHALL implement the stack, with PC_RAS_EN, as a RAS_DEPTH-entry LIFO with these behaviours:
- Push: call in RUN, not stalled, no higher-priority redirect, pushes pc+INC.
- Pop: ret in RUN pops and redirects.
- Call and ret together: pop-then-push; pc redirects to the popped value.
- Push when full: overwrites the top entry and sets ras_err.
- Pop when empty: redirects to pc+INC and sets ras_err.
- ras_err: cleared only by reset.
REQ-033 SHALL, without PC_RAS_EN, have no stack storage, ignore call and ret, tie ras_err to 0, and leave all other behaviour identical.

Verification
REQ-034 SHALL cover reset: rst pulse; release -> cycle 1 pc=0, pc_valid=0; cycle 2 pc_valid=1; cycle 3 pc=4.
REQ-035 SHALL cover stall vs. redirect: stall=1 and br_valid=1 with br_target=0x100 -> next pc=0x100; stall=1 alone for 3 cycles -> pc held constant.
REQ-036 SHALL cover priority: exc_valid, br_valid, and halt together at pc=0x40 -> pc=0x80, state RUN, pc_valid=1.
REQ-037 SHALL cover halt/resume: halt at pc=0x20 -> pc_valid=0 and pc=0x20 held 5 cycles; resume -> pc_valid=1, pc=0x20, then 0x24.
REQ-038 SHALL cover wrap: WIDTH=8, pc=0xFC, sequential step -> pc=0x00, no error.
REQ-039 SHALL cover the RAS (PC_RAS_EN, RAS_DEPTH=2):
- call at 0x10, then call at 0x50, then ret -> pc=0x54; second ret -> pc=0x14.
- third ret -> pc=pc+4 and ras_err=1.
